// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed (or LFSR-jittered) response latency.
// Optional feature: define IMEM_RANDOM_DELAY_EN to add 0..3 random extra wait cycles per fetch.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_data_o,
    output logic                     rsp_err_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [31:0]              wr_data_i
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [4:0]       cnt_r;
    logic [4:0]       cnt_s;
    logic [31:0]      data_r;
    logic             err_r;
    logic [31:0]      mem [DEPTH];

    logic             accept_s;
    logic [29:0]      off_word_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;
    logic [4:0]       extra_s;
    logic [4:0]       wait_total_s;

    // Address decode; BASE_ADDR is word aligned, so the word offset needs no borrow from bits [1:0].
    always_comb begin
        off_word_s = req_addr_i[31:2] - BASE_ADDR[31:2];
        err_s      = (req_addr_i[1:0] != 2'b00) | (req_addr_i < BASE_ADDR)
                   | (off_word_s >= 30'(DEPTH));
        idx_s      = off_word_s[IDX_W-1:0];
        accept_s   = req_valid_i & (state_r == IDLE);
    end

`ifdef IMEM_RANDOM_DELAY_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR (taps 16,14,13,11), advanced once per accepted fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= 16'hACE1;
        end else if (accept_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // Extra wait cycles drawn from the current LFSR value.
    always_comb begin
        extra_s = {3'b000, lfsr_r[1:0]};
    end
`else
    // Fixed latency build: no extra wait cycles.
    always_comb begin
        extra_s = 5'd0;
    end
`endif

    // Number of WAIT cycles between accept and RESP.
    always_comb begin
        wait_total_s = 5'(LATENCY - 1) + extra_s;
    end

    // Next-state logic for the IDLE/WAIT/RESP handshake sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (wait_total_s == 5'd0) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = wait_total_s - 5'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 5'd0) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 5'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 5'd0;
            end
        endcase
    end

    // State, counter and captured response; the array read here sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            data_r  <= 32'h0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                data_r <= err_s ? 32'h0 : mem[idx_s];
                err_r  <= err_s;
            end
        end
    end

    // Preload port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign req_ready_o = (state_r == IDLE);
    assign rsp_valid_o = (state_r == RESP);
    assign rsp_data_o  = data_r;
    assign rsp_err_o   = err_r;

endmodule
